spi_flash_arbiter: RTL and testbench



---
 rtl/spi_flash_arbiter.sv | 164 ++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// Two-port arbiter for the shared configuration SPI flash: whole-frame grants, CS-high gap, idle watchdog.
// Grant lands one cycle after the request sample; SPI pins are 1-cycle registered copies of the owner; losers wait.
module spi_flash_arbiter #(
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk_usb,
  input  logic reset_n,
  input  logic m0_req,
  output logic m0_gnt,
  input  logic m0_cs,
  input  logic m0_sck,
  input  logic m0_mosi,
  output logic m0_miso,
  input  logic m1_req,
  output logic m1_gnt,
  input  logic m1_cs,
  input  logic m1_sck,
  input  logic m1_mosi,
  output logic m1_miso,
  output logic spi_cs,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic owner,
  output logic busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  localparam logic [7:0]  GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic        WD_EN    = (TIMEOUT != 0);

  state_t      state;
  logic        last_served;
  logic [7:0]  gap_cnt;
  logic [15:0] wd_cnt;
  logic        lock0;
  logic        lock1;

  logic own_req;
  logic own_cs;
  logic own_sck;
  logic own_mosi;
  logic elig0;
  logic elig1;
  logic rel_norm;
  logic wd_fire;

  // Only the current owner's pins are ever looked at; everything else is ignored.
  always_comb begin
    own_req  = 1'b0;
    own_cs   = 1'b1;
    own_sck  = 1'b0;
    own_mosi = 1'b0;
    if (state == OWN0) begin
      own_req  = m0_req;
      own_cs   = m0_cs;
      own_sck  = m0_sck;
      own_mosi = m0_mosi;
    end else if (state == OWN1) begin
      own_req  = m1_req;
      own_cs   = m1_cs;
      own_sck  = m1_sck;
      own_mosi = m1_mosi;
    end
  end

  assign elig0    = m0_req & ~lock0;
  assign elig1    = m1_req & ~lock1;
  assign rel_norm = ~own_req & own_cs;
  assign wd_fire  = WD_EN & own_cs & (wd_cnt == WD_LAST);

  assign m0_miso = m0_gnt & spi_miso;
  assign m1_miso = m1_gnt & spi_miso;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      gap_cnt     <= 8'd0;
      wd_cnt      <= 16'd0;
      lock0       <= 1'b0;
      lock1       <= 1'b0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      owner       <= 1'b0;
      spi_cs      <= 1'b1;
      spi_sck     <= 1'b0;
      spi_mosi    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (!m0_req) lock0 <= 1'b0;
      if (!m1_req) lock1 <= 1'b0;

      case (state)
        IDLE: begin
          spi_cs   <= 1'b1;
          spi_sck  <= 1'b0;
          spi_mosi <= 1'b0;
          gap_cnt  <= 8'd0;
          wd_cnt   <= 16'd0;
          // Round-robin on a tie: the port that was not served last wins.
          if (elig0 && (!elig1 || last_served)) begin
            state  <= OWN0;
            m0_gnt <= 1'b1;
            owner  <= 1'b0;
          end else if (elig1) begin
            state  <= OWN1;
            m1_gnt <= 1'b1;
            owner  <= 1'b1;
          end
        end

        OWN0, OWN1: begin
          if (rel_norm || wd_fire) begin
            state       <= GAP;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            last_served <= (state == OWN1);
            spi_cs      <= 1'b1;
            spi_sck     <= 1'b0;
            spi_mosi    <= 1'b0;
            gap_cnt     <= 8'd0;
            wd_cnt      <= 16'd0;
            // A clean release wins over an expiry landing on the same cycle.
            if (!rel_norm) begin
              timeout_err <= 1'b1;
              if (state == OWN1) lock1 <= 1'b1;
              else               lock0 <= 1'b1;
            end
          end else begin
            spi_cs   <= own_cs;
            spi_sck  <= own_sck;
            spi_mosi <= own_mosi;
            if (!own_cs)
              wd_cnt <= 16'd0;
            else if (WD_EN)
              wd_cnt <= wd_cnt + 16'd1;
          end
        end

        GAP: begin
          spi_cs   <= 1'b1;
          spi_sck  <= 1'b0;
          spi_mosi <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state   <= IDLE;
            gap_cnt <= 8'd0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: stimulus queues expected grant/timeout events and pin values by cycle,
// a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_flash_arbiter;

  localparam int K_GUP = 0, K_GDN = 1, K_TUP = 2, K_TDN = 3;
  localparam int C_PIN = 0, C_MISO = 1, C_BUSY = 2;

  typedef struct {int kind; int port; int cyc;} ev_t;
  typedef struct {int kind; int cyc; logic [2:0] exp;} pin_t;

  ev_t  evq[$];
  ev_t  evq_b[$];
  pin_t pq[$];

  int checks = 0;
  int errors = 0;

  logic clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  int cyc = 0;
  always @(posedge clk_usb) cyc <= cyc + 1;

  // Instance A: CS_GAP=4, TIMEOUT=100
  logic       reset_n;
  logic [1:0] req, cs, sck, mosi;
  wire  [1:0] gnt, miso;
  logic       spi_miso;
  wire        spi_cs, spi_sck, spi_mosi, owner, busy, timeout_err;

  spi_flash_arbiter #(.CS_GAP(4), .TIMEOUT(100)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n),
    .m0_req(req[0]), .m0_gnt(gnt[0]), .m0_cs(cs[0]), .m0_sck(sck[0]), .m0_mosi(mosi[0]), .m0_miso(miso[0]),
    .m1_req(req[1]), .m1_gnt(gnt[1]), .m1_cs(cs[1]), .m1_sck(sck[1]), .m1_mosi(mosi[1]), .m1_miso(miso[1]),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  // Instance B: watchdog disabled
  logic       b_rst_n;
  logic [1:0] b_req, b_cs, b_sck, b_mosi;
  wire  [1:0] b_gnt, b_miso;
  logic       b_spi_miso;
  wire        b_spi_cs, b_spi_sck, b_spi_mosi, b_owner, b_busy, b_to;

  spi_flash_arbiter #(.CS_GAP(4), .TIMEOUT(0)) dut_b (
    .clk_usb(clk_usb), .reset_n(b_rst_n),
    .m0_req(b_req[0]), .m0_gnt(b_gnt[0]), .m0_cs(b_cs[0]), .m0_sck(b_sck[0]), .m0_mosi(b_mosi[0]), .m0_miso(b_miso[0]),
    .m1_req(b_req[1]), .m1_gnt(b_gnt[1]), .m1_cs(b_cs[1]), .m1_sck(b_sck[1]), .m1_mosi(b_mosi[1]), .m1_miso(b_miso[1]),
    .spi_cs(b_spi_cs), .spi_sck(b_spi_sck), .spi_mosi(b_spi_mosi), .spi_miso(b_spi_miso),
    .owner(b_owner), .busy(b_busy), .timeout_err(b_to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  task automatic push_ev(input int k, input int p, input int c);
    ev_t e;
    e.kind = k; e.port = p; e.cyc = c;
    evq.push_back(e);
  endtask

  task automatic push_evb(input int k, input int p, input int c);
    ev_t e;
    e.kind = k; e.port = p; e.cyc = c;
    evq_b.push_back(e);
  endtask

  task automatic push_pin(input int k, input int c, input logic [2:0] x);
    pin_t p;
    p.kind = k; p.cyc = c; p.exp = x;
    pq.push_back(p);
  endtask

  task automatic ev_obs(input int qi, input int kind, input int port);
    ev_t e;
    logic empty;
    empty = (qi == 0) ? (evq.size() == 0) : (evq_b.size() == 0);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL event(q%0d): got kind %0d port %0d at cycle %0d, expected none", qi, kind, port, cyc);
    end else begin
      if (qi == 0) e = evq.pop_front();
      else         e = evq_b.pop_front();
      if (e.kind != kind || e.port != port || e.cyc != cyc) begin
        errors++;
        $display("FAIL event(q%0d): got kind %0d port %0d cycle %0d, expected kind %0d port %0d cycle %0d",
                 qi, kind, port, cyc, e.kind, e.port, e.cyc);
      end
    end
  endtask

  // Release edge at r+1, then four GAP cycles and one IDLE cycle with CS high.
  task automatic gap_checks(input int r);
    for (int j = 1; j <= 5; j++) begin
      push_pin(C_PIN, r + j, 3'b100);
      push_pin(C_BUSY, r + j, (j <= 4) ? 3'b001 : 3'b000);
    end
  endtask

  // Drives an n-cycle CS-low frame on port p (already granted), then releases.
  task automatic frame(input int p, input int n, input int drop_at, output int r);
    logic [15:0] pat;
    logic [1:0]  em;
    pat = 16'hB38D;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) req[p] = 1'b0;
      cs[p]       = 1'b0;
      sck[p]      = i[0];
      mosi[p]     = pat[i % 16];
      cs[1-p]     = 1'($urandom_range(0, 1));
      sck[1-p]    = 1'($urandom_range(0, 1));
      mosi[1-p]   = 1'($urandom_range(0, 1));
      spi_miso    = 1'($urandom_range(0, 1));
      em          = 2'b00;
      em[p]       = spi_miso;
      push_pin(C_MISO, cyc, {1'b0, em});
      push_pin(C_PIN, cyc + 1, {1'b0, sck[p], mosi[p]});
      tick();
    end
    req[p]   = 1'b0;
    cs[p]    = 1'b1;
    sck[p]   = 1'b0;
    mosi[p]  = 1'b0;
    cs[1-p]  = 1'b1;
    sck[1-p] = 1'b0;
    mosi[1-p] = 1'b0;
    spi_miso = 1'b0;
    r = cyc;
    push_ev(K_GDN, p, r + 1);
    gap_checks(r);
  endtask

  initial begin
    logic [1:0] pg, pbg;
    logic       pt, pbt;
    pin_t       p;
    logic [2:0] act;
    pg = 2'b00; pbg = 2'b00; pt = 1'b0; pbt = 1'b0;
    forever begin
      @(negedge clk_usb);
      while (pq.size() > 0 && pq[0].cyc <= cyc) begin
        p = pq.pop_front();
        case (p.kind)
          C_PIN:   act = {spi_cs, spi_sck, spi_mosi};
          C_MISO:  act = {1'b0, miso};
          default: act = {2'b00, busy};
        endcase
        checks++;
        if (act !== p.exp || p.cyc != cyc) begin
          errors++;
          $display("FAIL pin(kind %0d) cycle %0d (at %0d): got %b expected %b", p.kind, p.cyc, cyc, act, p.exp);
        end
      end
      if (pg[0] && !gnt[0]) ev_obs(0, K_GDN, 0);
      if (pg[1] && !gnt[1]) ev_obs(0, K_GDN, 1);
      if (!pt && timeout_err) ev_obs(0, K_TUP, int'(owner));
      if (pt && !timeout_err) ev_obs(0, K_TDN, 0);
      if (!pg[0] && gnt[0]) begin ev_obs(0, K_GUP, 0); chk("owner_on_gnt0", owner, 0); end
      if (!pg[1] && gnt[1]) begin ev_obs(0, K_GUP, 1); chk("owner_on_gnt1", owner, 1); end
      if (pbg[0] && !b_gnt[0]) ev_obs(1, K_GDN, 0);
      if (pbg[1] && !b_gnt[1]) ev_obs(1, K_GDN, 1);
      if (!pbt && b_to) ev_obs(1, K_TUP, 0);
      if (!pbg[0] && b_gnt[0]) ev_obs(1, K_GUP, 0);
      if (!pbg[1] && b_gnt[1]) ev_obs(1, K_GUP, 1);
      pg = gnt; pbg = b_gnt; pt = timeout_err; pbt = b_to;
    end
  end

  task automatic seq_a();
    int c, r, r1, r2;
    reset_n = 1'b0;
    req = 2'b00; cs = 2'b11; sck = 2'b00; mosi = 2'b00; spi_miso = 1'b0;
    repeat (3) tick();
    chk("rst_spi_cs", spi_cs, 1);
    chk("rst_spi_sck", spi_sck, 0);
    chk("rst_spi_mosi", spi_mosi, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset_n = 1'b1;

    // Contention: both requests in the first IDLE cycle, port 0 wins.
    tick(); c = cyc;
    req = 2'b11;
    push_ev(K_GUP, 0, c + 1);
    tick();
    frame(0, 6, 99, r);
    push_ev(K_GUP, 1, r + 6);
    repeat (6) tick();
    req[0] = 1'b1;
    frame(1, 5, 99, r1);
    push_ev(K_GUP, 0, r1 + 6);
    repeat (6) tick();
    frame(0, 4, 99, r2);
    repeat (6) tick();

    // Single port 0 transfer with 16 SCK toggles.
    c = cyc; req[0] = 1'b1;
    push_ev(K_GUP, 0, c + 1);
    tick();
    frame(0, 17, 99, r);
    repeat (6) tick();

    // Request drops with CS still low: grant must hold for 10 more frame cycles.
    c = cyc; req[0] = 1'b1;
    push_ev(K_GUP, 0, c + 1);
    tick();
    frame(0, 12, 2, r);
    repeat (6) tick();

    // Watchdog on an idle port 1, port 0 queued meanwhile.
    c = cyc; req[1] = 1'b1; cs[1] = 1'b1;
    push_ev(K_GUP, 1, c + 1);
    push_ev(K_GDN, 1, c + 101);
    push_ev(K_TUP, 1, c + 101);
    push_ev(K_TDN, 0, c + 102);
    push_ev(K_GUP, 0, c + 106);
    push_pin(C_BUSY, c + 100, 3'b001);
    gap_checks(c + 100);
    repeat (50) tick();
    req[0] = 1'b1; cs[0] = 1'b1;
    repeat (56) tick();
    req[0] = 1'b0;
    push_ev(K_GDN, 0, cyc + 1);
    gap_checks(cyc);
    repeat (14) tick();
    req[1] = 1'b0;
    tick();
    req[1] = 1'b1;
    push_ev(K_GUP, 1, cyc + 1);
    tick();
    req[1] = 1'b0;
    push_ev(K_GDN, 1, cyc + 1);
    gap_checks(cyc);
    repeat (8) tick();

    // Leave last_served=0, then reset mid-frame and check the first tie after reset.
    c = cyc; req[0] = 1'b1;
    push_ev(K_GUP, 0, c + 1);
    tick();
    frame(0, 3, 99, r);
    repeat (6) tick();
    req[0] = 1'b1;
    push_ev(K_GUP, 0, cyc + 1);
    tick();
    cs[0] = 1'b0;
    tick();
    tick();
    chk("midframe_spi_cs", spi_cs, 0);
    push_ev(K_GDN, 0, cyc);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_spi_cs", spi_cs, 1);
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_sck", spi_sck, 0);
    req = 2'b11; cs = 2'b11;
    tick();
    reset_n = 1'b1;
    push_ev(K_GUP, 0, cyc + 1);
    tick();
    req[0] = 1'b0;
    push_ev(K_GDN, 0, cyc + 1);
    push_ev(K_GUP, 1, cyc + 6);
    gap_checks(cyc);
    repeat (6) tick();
    req[1] = 1'b0;
    push_ev(K_GDN, 1, cyc + 1);
    gap_checks(cyc);
    repeat (8) tick();
  endtask

  task automatic seq_b();
    b_rst_n = 1'b0;
    b_req = 2'b00; b_cs = 2'b11; b_sck = 2'b00; b_mosi = 2'b00; b_spi_miso = 1'b0;
    repeat (3) tick();
    b_rst_n = 1'b1;
    tick();
    b_req[0] = 1'b1;
    push_evb(K_GUP, 0, cyc + 1);
    repeat (66000) tick();
    chk("nowd_gnt_held", b_gnt[0], 1);
    chk("nowd_busy", b_busy, 1);
    b_req[0] = 1'b0;
    push_evb(K_GDN, 0, cyc + 1);
    repeat (8) tick();
  endtask

  initial begin
    ev_t  e;
    pin_t p;
    fork
      seq_a();
      seq_b();
    join
    repeat (4) tick();
    while (evq.size() > 0) begin
      e = evq.pop_front();
      checks++; errors++;
      $display("FAIL event missing: kind %0d port %0d cycle %0d never seen", e.kind, e.port, e.cyc);
    end
    while (evq_b.size() > 0) begin
      e = evq_b.pop_front();
      checks++; errors++;
      $display("FAIL event_b missing: kind %0d port %0d cycle %0d never seen", e.kind, e.port, e.cyc);
    end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      checks++; errors++;
      $display("FAIL pin unchecked: kind %0d cycle %0d expected %b", p.kind, p.cyc, p.exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
